digit_editor: RTL and testbench
===============================

DIGIT_EDITOR -- requirements
Module: digit_editor

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 8, number of editable digits (2..16).
REQ-002 SHALL have parameter RADIX, default 10, digit base (2..16).
REQ-003 SHALL have parameter CARRY, default 0; 1 makes up/down carry or borrow into higher digits.
REQ-004 SHALL have parameter REPEAT_DELAY, default 25_000_000, held cycles before the first auto-repeat.
REQ-005 SHALL have parameter REPEAT_RATE, default 5_000_000, cycles between later auto-repeats.
REQ-006 SHALL have parameter BLINK_HALF, default 12_500_000, cycles per blink half-period.
REQ-007 SHALL have port clk, input, 1 bit: clock, rising edge.
REQ-008 SHALL have port resetn, input, 1 bit: reset, asynchronous, active-low.
REQ-009 SHALL have ports up, down, left, right, input, 1 bit each: debounced level buttons.
REQ-010 SHALL have port load, input, 1 bit: synchronous value load strobe.
REQ-011 SHALL have port load_value, input, 4*NUM_DIGITS bits: digit i at bits [4i+3:4i].
REQ-012 SHALL have port digits, output, NUM_DIGITS x 4 bits: current digit values, index 0 rightmost.
REQ-013 SHALL have port cursor, output, $clog2(NUM_DIGITS) bits: selected digit index.
REQ-014 SHALL have port points, output, NUM_DIGITS bits: decimal point per digit (cursor marker).
REQ-015 SHALL have port changed, output, 1 bit: one-cycle pulse when any digit value changed.

Function
REQ-016 SHALL turn each button into action pulses: a button first sampled high at edge k (low at k-1) acts at edge k+1; if still held, again at edge k+1+REPEAT_DELAY, then every REPEAT_RATE cycles until released.
REQ-017 SHALL apply at most one action per cycle, priority load > left > right > up > down; lower-priority pulses in that cycle are dropped, not queued.
REQ-018 SHALL on left set cursor to (cursor+1) mod NUM_DIGITS, and on right to (cursor-1) mod NUM_DIGITS, wrapping at both ends.
REQ-019 SHALL with CARRY=0 on up set digits[cursor] to 0 if it equals RADIX-1, else increment it; on down set it to RADIX-1 if 0, else decrement it; other digits unchanged.
REQ-020 SHALL with CARRY=1 on up/down propagate carry/borrow from digit cursor toward NUM_DIGITS-1 in the same cycle; overflow/underflow past the top digit is discarded (wraps), digits below cursor are never touched.
REQ-021 SHALL on load copy load_value into digits, clamping any nibble >= RADIX to RADIX-1; cursor unchanged.
REQ-022 SHALL assert changed for exactly one cycle after an edge where any digit value changed; cursor moves and no-change loads do not assert it.
REQ-023 SHALL keep points[i]=0 for every i != cursor.
REQ-024 SHALL restart repeat timing for a button on every release; releasing mid-delay generates no further pulse.

Reset
REQ-025 SHALL on resetn low asynchronously clear digits to 0, cursor to 0, changed to 0, blink phase to on, and all repeat counters and button samples to 0.
REQ-026 SHALL treat a button held across reset release as a new press (first action one edge after first sampled high).

Configuration
REQ-027 SHALL, with DIGIT_EDITOR_BLINK_EN defined, drive points[cursor] with a square wave toggling every BLINK_HALF cycles, phase restarted to on at every cursor move.
REQ-028 SHALL, without DIGIT_EDITOR_BLINK_EN, drive points[cursor]=1 steadily and contain no blink counter.

Structure
REQ-029 SHALL place digit_t (4-bit logic) and the action enum (ACT_NONE, ACT_LOAD, ACT_LEFT, ACT_RIGHT, ACT_UP, ACT_DOWN) in shared package digit_editor_pkg.
REQ-030 SHALL implement press/auto-repeat in sub-module key_repeat (clk, resetn, level in, pulse out, REPEAT_DELAY/REPEAT_RATE parameters), instantiated four times.

Verification
REQ-031 SHALL cover: reset, up pulse 1 cycle -> digits[0]=1 at next edge, changed high one cycle.
REQ-032 SHALL cover: RADIX=10, CARRY=0, digits[0]=9, up -> digits[0]=0, digits[1] unchanged; down at 0 -> 9.
REQ-033 SHALL cover: CARRY=1, digits={..,0,9,9}, cursor 0, up -> {..,1,0,0}; all nines up -> all zeros.
REQ-034 SHALL cover: cursor 0, right -> cursor NUM_DIGITS-1; left and up same cycle -> cursor 1, digits unchanged.
REQ-035 SHALL cover: REPEAT_DELAY=10, REPEAT_RATE=4, up held 30 cycles -> actions at edges k+1, k+11, k+15, k+19, k+23, k+27, k+31 while held.
REQ-036 SHALL cover: RADIX=8, load with nibble 0xC -> digit 7; load and up same cycle -> load wins, up dropped.

Source files
------------

// File: rtl/digit_editor_pkg.sv
// Shared types for the digit editor: digit nibble, action codes and key-repeat states.
package digit_editor_pkg;

  typedef logic [3:0] digit_t;

  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_LOAD,
    ACT_LEFT,
    ACT_RIGHT,
    ACT_UP,
    ACT_DOWN
  } action_t;

  typedef enum logic [1:0] {
    KS_IDLE,
    KS_DELAY,
    KS_RATE
  } key_state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_repeat.sv
// Turns a held level into a one-cycle pulse on press, then after REPEAT_DELAY,
// then every REPEAT_RATE cycles until release.
module key_repeat
  import digit_editor_pkg::*;
#(
  parameter int unsigned REPEAT_DELAY = 25_000_000,
  parameter int unsigned REPEAT_RATE  = 5_000_000
) (
  input  logic clk,
  input  logic resetn,
  input  logic level,
  output logic pulse
);

  localparam int unsigned CW = $clog2(max_u(REPEAT_DELAY, REPEAT_RATE) + 1);

  key_state_t    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          pulse_nxt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= KS_IDLE;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      pulse <= pulse_nxt;
    end
  end

  // cnt counts edges since the last pulse; any release drops back to idle
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pulse_nxt = 1'b0;
    case (state)
      KS_IDLE: begin
        cnt_nxt = '0;
        if (level) begin
          state_nxt = KS_DELAY;
          pulse_nxt = 1'b1;
        end
      end
      KS_DELAY: begin
        if (!level) begin
          state_nxt = KS_IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CW'(REPEAT_DELAY - 1)) begin
          state_nxt = KS_RATE;
          cnt_nxt   = '0;
          pulse_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      KS_RATE: begin
        if (!level) begin
          state_nxt = KS_IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CW'(REPEAT_RATE - 1)) begin
          cnt_nxt   = '0;
          pulse_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = KS_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: rtl/digit_editor.sv
// Button-driven multi-digit editor with cursor, wrap/carry arithmetic and load.
// Optional cursor blinking is enabled with `define DIGIT_EDITOR_BLINK_EN.
module digit_editor
  import digit_editor_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned RADIX        = 10,
  parameter int unsigned CARRY        = 0,
  parameter int unsigned REPEAT_DELAY = 25_000_000,
  parameter int unsigned REPEAT_RATE  = 5_000_000,
  parameter int unsigned BLINK_HALF   = 12_500_000
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          up,
  input  logic                          down,
  input  logic                          left,
  input  logic                          right,
  input  logic                          load,
  input  logic [4*NUM_DIGITS-1:0]       load_value,
  output digit_t [NUM_DIGITS-1:0]       digits,
  output logic [$clog2(NUM_DIGITS)-1:0] cursor,
  output logic [NUM_DIGITS-1:0]         points,
  output logic                          changed
);

  localparam int unsigned CURW = $clog2(NUM_DIGITS);
  localparam digit_t      TOP  = digit_t'(RADIX - 1);

  logic up_p, down_p, left_p, right_p;

  key_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE))
    u_key_up    (.clk(clk), .resetn(resetn), .level(up),    .pulse(up_p));
  key_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE))
    u_key_down  (.clk(clk), .resetn(resetn), .level(down),  .pulse(down_p));
  key_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE))
    u_key_left  (.clk(clk), .resetn(resetn), .level(left),  .pulse(left_p));
  key_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE))
    u_key_right (.clk(clk), .resetn(resetn), .level(right), .pulse(right_p));

  action_t                 act;
  digit_t [NUM_DIGITS-1:0] digits_nxt;
  logic [CURW-1:0]         cursor_nxt;
  logic [NUM_DIGITS-1:0]   points_nxt;
  logic                    carry;
  logic                    mark_on;

  // One action per cycle; lower-priority pulses in the same cycle are lost
  always_comb begin
    act        = ACT_NONE;
    digits_nxt = digits;
    cursor_nxt = cursor;
    carry      = 1'b0;
    if      (load)    act = ACT_LOAD;
    else if (left_p)  act = ACT_LEFT;
    else if (right_p) act = ACT_RIGHT;
    else if (up_p)    act = ACT_UP;
    else if (down_p)  act = ACT_DOWN;
    case (act)
      ACT_LOAD: begin
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
          digits_nxt[i] = ({1'b0, load_value[4*i +: 4]} >= 5'(RADIX)) ? TOP
                                                                       : load_value[4*i +: 4];
        end
      end
      ACT_LEFT:  cursor_nxt = (cursor == CURW'(NUM_DIGITS - 1)) ? '0 : cursor + CURW'(1);
      ACT_RIGHT: cursor_nxt = (cursor == '0) ? CURW'(NUM_DIGITS - 1) : cursor - CURW'(1);
      ACT_UP, ACT_DOWN: begin
        // carry is only ever set at or above the cursor, so lower digits stay put
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
          if (cursor == CURW'(i) || carry) begin
            if (act == ACT_UP) begin
              if (digits[i] == TOP) begin
                digits_nxt[i] = '0;
                carry         = (CARRY != 0);
              end else begin
                digits_nxt[i] = digits[i] + digit_t'(1);
                carry         = 1'b0;
              end
            end else begin
              if (digits[i] == '0) begin
                digits_nxt[i] = TOP;
                carry         = (CARRY != 0);
              end else begin
                digits_nxt[i] = digits[i] - digit_t'(1);
                carry         = 1'b0;
              end
            end
          end
        end
      end
      default: ;
    endcase
  end

`ifdef DIGIT_EDITOR_BLINK_EN
  localparam int unsigned BW = $clog2(BLINK_HALF + 1);

  logic [BW-1:0] blink_cnt, blink_cnt_nxt;
  logic          blink_on, blink_on_nxt;

  // Square wave for the cursor marker, restarted in the on phase at every move
  always_comb begin
    blink_cnt_nxt = blink_cnt + BW'(1);
    blink_on_nxt  = blink_on;
    if (act == ACT_LEFT || act == ACT_RIGHT) begin
      blink_cnt_nxt = '0;
      blink_on_nxt  = 1'b1;
    end else if (blink_cnt == BW'(BLINK_HALF - 1)) begin
      blink_cnt_nxt = '0;
      blink_on_nxt  = ~blink_on;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else begin
      blink_cnt <= blink_cnt_nxt;
      blink_on  <= blink_on_nxt;
    end
  end

  assign mark_on = blink_on_nxt;
`else
  logic unused_blink;
  assign unused_blink = |BLINK_HALF;
  assign mark_on      = 1'b1;
`endif

  assign points_nxt = mark_on ? (NUM_DIGITS'(1) << cursor_nxt) : '0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      digits  <= '0;
      cursor  <= '0;
      points  <= NUM_DIGITS'(1);
      changed <= 1'b0;
    end else begin
      digits  <= digits_nxt;
      cursor  <= cursor_nxt;
      points  <= points_nxt;
      changed <= (digits_nxt != digits);
    end
  end

endmodule

// File: tb/tb_digit_editor.sv
// Directed bench for digit_editor: three instances (plain decimal, decimal with
// carry, octal) driven by shared buttons, each check against hand-derived values.
module tb_digit_editor;

  logic        clk = 1'b0;
  logic        resetn;
  logic        up, down, left, right, load;
  logic [15:0] load_value;

  logic [15:0] d0_digits, d1_digits, d2_digits;
  logic [1:0]  d0_cursor, d1_cursor, d2_cursor;
  logic [3:0]  d0_points, d1_points, d2_points;
  logic        d0_changed, d1_changed, d2_changed;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  digit_editor #(.NUM_DIGITS(4), .RADIX(10), .CARRY(0), .REPEAT_DELAY(10),
                 .REPEAT_RATE(4), .BLINK_HALF(6)) dut0 (
    .clk(clk), .resetn(resetn), .up(up), .down(down), .left(left), .right(right),
    .load(load), .load_value(load_value), .digits(d0_digits), .cursor(d0_cursor),
    .points(d0_points), .changed(d0_changed));

  digit_editor #(.NUM_DIGITS(4), .RADIX(10), .CARRY(1), .REPEAT_DELAY(10),
                 .REPEAT_RATE(4), .BLINK_HALF(6)) dut1 (
    .clk(clk), .resetn(resetn), .up(up), .down(down), .left(left), .right(right),
    .load(load), .load_value(load_value), .digits(d1_digits), .cursor(d1_cursor),
    .points(d1_points), .changed(d1_changed));

  digit_editor #(.NUM_DIGITS(4), .RADIX(8), .CARRY(0), .REPEAT_DELAY(10),
                 .REPEAT_RATE(4), .BLINK_HALF(6)) dut2 (
    .clk(clk), .resetn(resetn), .up(up), .down(down), .left(left), .right(right),
    .load(load), .load_value(load_value), .digits(d2_digits), .cursor(d2_cursor),
    .points(d2_points), .changed(d2_changed));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // b: 0 up, 1 down, 2 left, 3 right; the action lands on the second edge
  task automatic press(input int b);
    case (b)
      0: up    = 1'b1;
      1: down  = 1'b1;
      2: left  = 1'b1;
      default: right = 1'b1;
    endcase
    step();
    up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0;
    step();
  endtask

  task automatic do_load(input logic [15:0] v);
    load_value = v;
    load       = 1'b1;
    step();
    load       = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({d0_digits, d1_digits, d2_digits} !== 48'h0) begin
      n_fail++; $display("FAIL reset_digits: got %h %h %h want 0", d0_digits, d1_digits, d2_digits);
    end
    n_tests++;
    if (d0_cursor !== 2'd0 || d0_changed !== 1'b0) begin
      n_fail++; $display("FAIL reset_cursor_changed: got %0d %b want 0 0", d0_cursor, d0_changed);
    end
    n_tests++;
    if (d0_points !== 4'b0001) begin
      n_fail++; $display("FAIL reset_points: got %b want 0001", d0_points);
    end
    resetn = 1'b1;
    step();
  endtask

  task automatic test_up_pulse();
    up = 1'b1;
    step();
    n_tests++;
    if (d0_digits !== 16'h0000) begin
      n_fail++; $display("FAIL up_early: got %h want 0000", d0_digits);
    end
    up = 1'b0;
    step();
    n_tests++;
    if (d0_digits !== 16'h0001 || d0_changed !== 1'b1) begin
      n_fail++; $display("FAIL up_pulse: got %h chg %b want 0001 chg 1", d0_digits, d0_changed);
    end
    step();
    n_tests++;
    if (d0_changed !== 1'b0) begin
      n_fail++; $display("FAIL changed_one_cycle: got %b want 0", d0_changed);
    end
  endtask

  task automatic test_wrap();
    do_load(16'h0019);
    press(0);
    n_tests++;
    if (d0_digits !== 16'h0010) begin
      n_fail++; $display("FAIL wrap_up: got %h want 0010", d0_digits);
    end
    press(1);
    n_tests++;
    if (d0_digits !== 16'h0019) begin
      n_fail++; $display("FAIL wrap_down: got %h want 0019", d0_digits);
    end
  endtask

  task automatic test_carry();
    do_load(16'h0099);
    press(0);
    n_tests++;
    if (d1_digits !== 16'h0100 || d1_changed !== 1'b1) begin
      n_fail++; $display("FAIL carry_099: got %h chg %b want 0100 chg 1", d1_digits, d1_changed);
    end
    do_load(16'h9999);
    press(0);
    n_tests++;
    if (d1_digits !== 16'h0000) begin
      n_fail++; $display("FAIL carry_all_nines: got %h want 0000", d1_digits);
    end
    n_tests++;
    if (d0_digits !== 16'h9990) begin
      n_fail++; $display("FAIL nocarry_nines: got %h want 9990", d0_digits);
    end
  endtask

  task automatic test_cursor();
    do_load(16'h1234);
    press(3);
    n_tests++;
    if (d0_cursor !== 2'd3 || d0_points !== 4'b1000) begin
      n_fail++; $display("FAIL right_wrap: got cur %0d pts %b want 3 1000", d0_cursor, d0_points);
    end
    n_tests++;
    if (d0_changed !== 1'b0) begin
      n_fail++; $display("FAIL move_no_changed: got %b want 0", d0_changed);
    end
    press(2);
    n_tests++;
    if (d0_cursor !== 2'd0) begin
      n_fail++; $display("FAIL left_wrap: got %0d want 0", d0_cursor);
    end
    left = 1'b1; up = 1'b1;
    step();
    left = 1'b0; up = 1'b0;
    step();
    n_tests++;
    if (d0_cursor !== 2'd1 || d0_digits !== 16'h1234 || d0_changed !== 1'b0) begin
      n_fail++; $display("FAIL left_beats_up: got cur %0d %h chg %b want 1 1234 0",
                         d0_cursor, d0_digits, d0_changed);
    end
    step();
    n_tests++;
    if (d0_digits !== 16'h1234) begin
      n_fail++; $display("FAIL up_not_queued: got %h want 1234", d0_digits);
    end
  endtask

  task automatic test_repeat();
    logic exp;
    do_load(16'h0000);
    up = 1'b1;
    for (int e = 0; e <= 34; e++) begin
      step();
      exp = (e == 1 || e == 11 || e == 15 || e == 19 || e == 23 || e == 27 || e == 31);
      n_tests++;
      if (d0_changed !== exp) begin
        n_fail++; $display("FAIL repeat_edge_%0d: got %b want %b", e, d0_changed, exp);
      end
      if (e == 30) up = 1'b0;
    end
    n_tests++;
    if (d0_digits !== 16'h0070) begin
      n_fail++; $display("FAIL repeat_count: got %h want 0070", d0_digits);
    end
  endtask

  task automatic test_release_mid_delay();
    do_load(16'h0000);
    up = 1'b1;
    repeat (5) step();
    up = 1'b0;
    repeat (15) step();
    n_tests++;
    if (d0_digits !== 16'h0010) begin
      n_fail++; $display("FAIL release_mid_delay: got %h want 0010", d0_digits);
    end
    press(0);
    n_tests++;
    if (d0_digits !== 16'h0020) begin
      n_fail++; $display("FAIL repress: got %h want 0020", d0_digits);
    end
  endtask

  task automatic test_load_clamp();
    do_load(16'h0C35);
    n_tests++;
    if (d2_digits !== 16'h0735 || d2_changed !== 1'b1) begin
      n_fail++; $display("FAIL load_clamp: got %h chg %b want 0735 chg 1", d2_digits, d2_changed);
    end
    up = 1'b1;
    step();
    up = 1'b0;
    do_load(16'h0123);
    n_tests++;
    if (d2_digits !== 16'h0123 || d0_digits !== 16'h0123) begin
      n_fail++; $display("FAIL load_beats_up: got %h %h want 0123", d2_digits, d0_digits);
    end
    repeat (2) step();
    n_tests++;
    if (d2_digits !== 16'h0123) begin
      n_fail++; $display("FAIL up_dropped_after_load: got %h want 0123", d2_digits);
    end
    do_load(16'h0123);
    n_tests++;
    if (d2_changed !== 1'b0) begin
      n_fail++; $display("FAIL same_load_no_changed: got %b want 0", d2_changed);
    end
    n_tests++;
    if (d0_points !== 4'b0010 || d2_cursor !== 2'd1) begin
      n_fail++; $display("FAIL points_cursor: got %b cur %0d want 0010 1", d0_points, d2_cursor);
    end
  endtask

  initial begin
    resetn = 1'b0; up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0;
    load = 1'b0; load_value = '0;
    test_reset();
    test_up_pulse();
    test_wrap();
    test_carry();
    test_cursor();
    test_repeat();
    test_release_mid_delay();
    test_load_clamp();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
